// File: rtl/plot_scheduler.sv
// plot_scheduler: round-robin arbiter that sequences optional erase and draw
// rectangles from the ball, paddle and block sources onto a single plotter.
module plot_scheduler #(
   parameter int unsigned MAX_X         = 159,
   parameter int unsigned MAX_Y         = 119,
   parameter logic [2:0]  BG_COLOUR     = 3'b000,
   parameter logic [2:0]  BALL_COLOUR   = 3'b111,
   parameter logic [2:0]  PADDLE_COLOUR = 3'b010,
   parameter logic [2:0]  BLOCK_COLOUR  = 3'b100
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic [2:0]  req,
   input  logic [2:0]  erase_en,
   input  logic [2:0]  draw_en,
   input  logic [23:0] new_x,
   input  logic [20:0] new_y,
   input  logic [23:0] old_x,
   input  logic [20:0] old_y,
   input  logic [23:0] size_x,
   input  logic [20:0] size_y,
   output logic [2:0]  ack,
   output logic        plot_start,
   output logic [7:0]  plot_x,
   output logic [6:0]  plot_y,
   output logic [7:0]  plot_w,
   output logic [6:0]  plot_h,
   output logic [2:0]  plot_colour,
   input  logic        plot_done,
   output logic        busy
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ERASE_START,
      S_ERASE_WAIT,
      S_DRAW_START,
      S_DRAW_WAIT,
      S_ACK
   } state_t;

   localparam logic [7:0] MAX_X8 = 8'(MAX_X);
   localparam logic [6:0] MAX_Y7 = 7'(MAX_Y);
   localparam logic [8:0] X_END  = 9'(MAX_X + 1);
   localparam logic [7:0] Y_END  = 8'(MAX_Y + 1);

   function automatic logic [7:0] sel8(input logic [23:0] v, input logic [1:0] i);
      case (i)
         2'd1:    return v[15:8];
         2'd2:    return v[23:16];
         default: return v[7:0];
      endcase
   endfunction

   function automatic logic [6:0] sel7(input logic [20:0] v, input logic [1:0] i);
      case (i)
         2'd1:    return v[13:7];
         2'd2:    return v[20:14];
         default: return v[6:0];
      endcase
   endfunction

   function automatic logic [2:0] src_colour(input logic [1:0] i);
      case (i)
         2'd1:    return PADDLE_COLOUR;
         2'd2:    return BLOCK_COLOUR;
         default: return BALL_COLOUR;
      endcase
   endfunction

   function automatic logic phase_ok(input logic en, input logic [7:0] x, input logic [6:0] y,
                                     input logic [7:0] w, input logic [6:0] h);
      return en && (x <= MAX_X8) && (y <= MAX_Y7) && (w != '0) && (h != '0);
   endfunction

   // Remaining room is computed one bit wider so a full-width rectangle cannot wrap.
   function automatic logic [7:0] clip_w(input logic [7:0] x, input logic [7:0] w);
      logic [8:0] room;
      room = X_END - {1'b0, x};
      return ({1'b0, w} < room) ? w : room[7:0];
   endfunction

   function automatic logic [6:0] clip_h(input logic [6:0] y, input logic [6:0] h);
      logic [7:0] room;
      room = Y_END - {1'b0, y};
      return ({1'b0, h} < room) ? h : room[6:0];
   endfunction

   state_t     state_q, state_d;
   logic [1:0] last_q, last_d;
   logic [1:0] win_q, win_d;
   logic       den_q, den_d;
   logic [7:0] nx_q, nx_d;
   logic [6:0] ny_q, ny_d;
   logic [7:0] sx_q, sx_d;
   logic [6:0] sy_q, sy_d;
   logic [7:0] px_q, px_d;
   logic [6:0] py_q, py_d;
   logic [7:0] pw_q, pw_d;
   logic [6:0] ph_q, ph_d;
   logic [2:0] pc_q, pc_d;

   logic       gnt_found;
   logic [1:0] gnt;
   logic [1:0] cand;

   always_comb begin
      gnt_found = 1'b0;
      gnt       = '0;
      cand      = '0;
      for (int unsigned k = 0; k < 3; k++) begin
         cand = 2'((32'(last_q) + 32'd1 + k) % 32'd3);
         if (!gnt_found && req[cand]) begin
            gnt_found = 1'b1;
            gnt       = cand;
         end
      end
   end

   logic [7:0] g_ox, g_nx, g_sx;
   logic [6:0] g_oy, g_ny, g_sy;
   logic       g_erase_ok, g_draw_ok, q_draw_ok;

   assign g_ox       = sel8(old_x, gnt);
   assign g_oy       = sel7(old_y, gnt);
   assign g_nx       = sel8(new_x, gnt);
   assign g_ny       = sel7(new_y, gnt);
   assign g_sx       = sel8(size_x, gnt);
   assign g_sy       = sel7(size_y, gnt);
   assign g_erase_ok = phase_ok(erase_en[gnt], g_ox, g_oy, g_sx, g_sy);
   assign g_draw_ok  = phase_ok(draw_en[gnt], g_nx, g_ny, g_sx, g_sy);
   assign q_draw_ok  = phase_ok(den_q, nx_q, ny_q, sx_q, sy_q);

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      win_d   = win_q;
      den_d   = den_q;
      nx_d    = nx_q;
      ny_d    = ny_q;
      sx_d    = sx_q;
      sy_d    = sy_q;
      px_d    = px_q;
      py_d    = py_q;
      pw_d    = pw_q;
      ph_d    = ph_q;
      pc_d    = pc_q;
      case (state_q)
         S_IDLE: begin
            if (gnt_found) begin
               win_d = gnt;
               den_d = draw_en[gnt];
               nx_d  = g_nx;
               ny_d  = g_ny;
               sx_d  = g_sx;
               sy_d  = g_sy;
               // The first phase is loaded straight from the inputs so it can start next cycle.
               if (g_erase_ok) begin
                  state_d = S_ERASE_START;
                  px_d    = g_ox;
                  py_d    = g_oy;
                  pw_d    = clip_w(g_ox, g_sx);
                  ph_d    = clip_h(g_oy, g_sy);
                  pc_d    = BG_COLOUR;
               end else if (g_draw_ok) begin
                  state_d = S_DRAW_START;
                  px_d    = g_nx;
                  py_d    = g_ny;
                  pw_d    = clip_w(g_nx, g_sx);
                  ph_d    = clip_h(g_ny, g_sy);
                  pc_d    = src_colour(gnt);
               end else begin
                  state_d = S_ACK;
               end
            end
         end
         S_ERASE_START: state_d = S_ERASE_WAIT;
         S_ERASE_WAIT: begin
            if (plot_done) begin
               if (q_draw_ok) begin
                  state_d = S_DRAW_START;
                  px_d    = nx_q;
                  py_d    = ny_q;
                  pw_d    = clip_w(nx_q, sx_q);
                  ph_d    = clip_h(ny_q, sy_q);
                  pc_d    = src_colour(win_q);
               end else begin
                  state_d = S_ACK;
               end
            end
         end
         S_DRAW_START: state_d = S_DRAW_WAIT;
         S_DRAW_WAIT: begin
            if (plot_done) state_d = S_ACK;
         end
         S_ACK: begin
            last_d  = win_q;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= S_IDLE;
         last_q  <= 2'd2;
         win_q   <= '0;
         den_q   <= 1'b0;
         nx_q    <= '0;
         ny_q    <= '0;
         sx_q    <= '0;
         sy_q    <= '0;
         px_q    <= '0;
         py_q    <= '0;
         pw_q    <= '0;
         ph_q    <= '0;
         pc_q    <= '0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         win_q   <= win_d;
         den_q   <= den_d;
         nx_q    <= nx_d;
         ny_q    <= ny_d;
         sx_q    <= sx_d;
         sy_q    <= sy_d;
         px_q    <= px_d;
         py_q    <= py_d;
         pw_q    <= pw_d;
         ph_q    <= ph_d;
         pc_q    <= pc_d;
      end
   end

   assign plot_start  = (state_q == S_ERASE_START) || (state_q == S_DRAW_START);
   assign ack         = (state_q == S_ACK) ? (3'b001 << win_q) : '0;
   assign busy        = (state_q != S_IDLE);
   assign plot_x      = px_q;
   assign plot_y      = py_q;
   assign plot_w      = pw_q;
   assign plot_h      = ph_q;
   assign plot_colour = pc_q;

endmodule

// File: tb/tb_plot_scheduler.sv
// Scoreboard bench for plot_scheduler: a reference model queues the expected
// plotter starts and acks; a negedge monitor pops and compares them.
module tb_plot_scheduler;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic [2:0]  req = '0;
   logic [2:0]  erase_en = '0;
   logic [2:0]  draw_en = '0;
   logic [23:0] new_x = '0;
   logic [20:0] new_y = '0;
   logic [23:0] old_x = '0;
   logic [20:0] old_y = '0;
   logic [23:0] size_x = '0;
   logic [20:0] size_y = '0;
   logic [2:0]  ack;
   logic        plot_start;
   logic [7:0]  plot_x;
   logic [6:0]  plot_y;
   logic [7:0]  plot_w;
   logic [6:0]  plot_h;
   logic [2:0]  plot_colour;
   logic        plot_done = 1'b0;
   logic        busy;

   plot_scheduler #(
      .MAX_X(159),
      .MAX_Y(119)
   ) dut (
      .clk(clk),
      .resetn(resetn),
      .req(req),
      .erase_en(erase_en),
      .draw_en(draw_en),
      .new_x(new_x),
      .new_y(new_y),
      .old_x(old_x),
      .old_y(old_y),
      .size_x(size_x),
      .size_y(size_y),
      .ack(ack),
      .plot_start(plot_start),
      .plot_x(plot_x),
      .plot_y(plot_y),
      .plot_w(plot_w),
      .plot_h(plot_h),
      .plot_colour(plot_colour),
      .plot_done(plot_done),
      .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      int is_start;
      int x, y, w, h, col;
      int ackv;
      int t;
   } ev_t;

   ev_t sb[$];
   int  checks = 0;
   int  errors = 0;
   int  cyc = 0;
   int  lat = 3;
   int  pcnt = 0;
   int  n_done = 0;
   int  n_start = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic int ref_ok(int en, int x, int y, int w, int h);
      return (en != 0 && x <= 159 && y <= 119 && w > 0 && h > 0) ? 1 : 0;
   endfunction

   function automatic int ref_min(int a, int b);
      return (a < b) ? a : b;
   endfunction

   function automatic int ref_colour(int s);
      return (s == 0) ? 7 : (s == 1) ? 2 : 4;
   endfunction

   // Drives one source's fields and queues the events the scheduler should produce.
   // n >= 0 gives the IDLE sampling cycle so event timing is checked too.
   task automatic service(input int s, input int ee, input int de,
                          input int ox, input int oy, input int nx, input int ny,
                          input int w, input int h, input int n);
      ev_t e;
      int  t;
      old_x[s*8 +: 8]  = 8'(ox);
      old_y[s*7 +: 7]  = 7'(oy);
      new_x[s*8 +: 8]  = 8'(nx);
      new_y[s*7 +: 7]  = 7'(ny);
      size_x[s*8 +: 8] = 8'(w);
      size_y[s*7 +: 7] = 7'(h);
      erase_en[s]      = (ee != 0);
      draw_en[s]       = (de != 0);
      t = (n >= 0) ? n + 1 : -1;
      if (ref_ok(ee, ox, oy, w, h) != 0) begin
         e = '{1, ox, oy, ref_min(w, 160 - ox), ref_min(h, 120 - oy), 0, 0, t};
         sb.push_back(e);
         if (t >= 0) t += lat + 1;
      end
      if (ref_ok(de, nx, ny, w, h) != 0) begin
         e = '{1, nx, ny, ref_min(w, 160 - nx), ref_min(h, 120 - ny), ref_colour(s), 0, t};
         sb.push_back(e);
         if (t >= 0) t += lat + 1;
      end
      e = '{0, 0, 0, 0, 0, 0, 1 << s, t};
      sb.push_back(e);
   endtask

   task automatic wait_ack(input int s, input int budget);
      int k;
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!ack[s] && k < budget);
      if (!ack[s]) check("ack_timeout", 32'(ack[s]), 1);
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Plotter model: plot_done pulses exactly lat cycles after each plot_start.
   initial forever begin
      @(negedge clk);
      plot_done = 1'b0;
      if (plot_start) begin
         pcnt = lat;
      end else if (pcnt > 0) begin
         pcnt--;
         if (pcnt == 0) begin
            plot_done = 1'b1;
            n_done++;
         end
      end
   end

   initial forever begin
      ev_t e;
      @(negedge clk);
      if (resetn && (plot_start || ack != '0)) begin
         if (plot_start) n_start++;
         if (sb.size() == 0) begin
            check("unexp_start", 32'(plot_start), 0);
            check("unexp_ack", 32'(ack), 0);
         end else begin
            e = sb.pop_front();
            check("start", 32'(plot_start), 32'(e.is_start));
            check("ack", 32'(ack), 32'(e.ackv));
            if (e.is_start != 0) begin
               check("plot_x", 32'(plot_x), 32'(e.x));
               check("plot_y", 32'(plot_y), 32'(e.y));
               check("plot_w", 32'(plot_w), 32'(e.w));
               check("plot_h", 32'(plot_h), 32'(e.h));
               check("plot_colour", 32'(plot_colour), 32'(e.col));
            end
            if (e.t >= 0) check("event_cycle", 32'(cyc), 32'(e.t));
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, acks, k, starts0, done0;

      repeat (3) @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);
      check("rst_busy", 32'(busy), 0);
      check("rst_ack", 32'(ack), 0);
      check("rst_start", 32'(plot_start), 0);
      check("rst_x", 32'(plot_x), 0);
      check("rst_colour", 32'(plot_colour), 0);

      // All three held: round-robin from ball
      lat = 2;
      for (int r = 0; r < 2; r++) begin
         service(0, 1, 1, 10, 10, 11, 11, 3, 3, -1);
         service(1, 1, 1, 60, 110, 62, 110, 20, 2, -1);
         service(2, 1, 1, 100, 40, 100, 40, 8, 4, -1);
      end
      @(negedge clk);
      req = 3'b111;
      acks = 0;
      k = 0;
      while (acks < 6 && k < 400) begin
         @(negedge clk);
         k++;
         if (ack != '0) acks++;
      end
      req = '0;
      check("rr_acks", 32'(acks), 6);

      // Ball erase+draw with exact timing
      lat = 3;
      @(negedge clk);
      n = cyc;
      service(0, 1, 1, 50, 4, 51, 5, 4, 4, n);
      req[0] = 1'b1;
      @(negedge clk);
      check("busy_active", 32'(busy), 1);
      wait_ack(0, 40);
      req[0] = 1'b0;

      // Paddle clipping: off-screen y, then right-edge clip
      @(negedge clk);
      n = cyc;
      service(1, 0, 1, 0, 0, 150, 125, 16, 1, n);
      req[1] = 1'b1;
      wait_ack(1, 40);
      req[1] = 1'b0;
      @(negedge clk);
      n = cyc;
      service(1, 0, 1, 0, 0, 150, 117, 16, 1, n);
      req[1] = 1'b1;
      wait_ack(1, 40);
      req[1] = 1'b0;

      // Block erase only; left-over draw data must be ignored
      @(negedge clk);
      n = cyc;
      service(2, 1, 0, 155, 118, 5, 5, 9, 9, n);
      req[2] = 1'b1;
      wait_ack(2, 40);
      req[2] = 1'b0;

      // Ball with no phases: ack one cycle after grant
      @(negedge clk);
      n = cyc;
      service(0, 0, 0, 1, 1, 2, 2, 4, 4, n);
      req[0] = 1'b1;
      wait_ack(0, 40);
      req[0] = 1'b0;

      // Reset during DRAW_WAIT of a block request
      lat = 30;
      @(negedge clk);
      n = cyc;
      service(2, 0, 1, 0, 0, 20, 30, 8, 8, n);
      req[2] = 1'b1;
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!plot_start && k < 20);
      check("abort_start_seen", 32'(plot_start), 1);
      repeat (3) @(negedge clk);
      resetn = 1'b0;
      req = '0;
      #1;
      check("abort_busy", 32'(busy), 0);
      check("abort_ack", 32'(ack), 0);
      check("abort_start", 32'(plot_start), 0);
      check("abort_x", 32'(plot_x), 0);
      check("abort_y", 32'(plot_y), 0);
      check("abort_w", 32'(plot_w), 0);
      check("abort_h", 32'(plot_h), 0);
      check("abort_colour", 32'(plot_colour), 0);
      sb.delete();
      repeat (2) @(negedge clk);
      resetn = 1'b1;
      starts0 = n_start;
      done0 = n_done;
      repeat (40) @(negedge clk);
      check("stray_done_seen", 32'(n_done - done0), 1);
      check("stray_start", 32'(n_start - starts0), 0);
      check("stray_busy", 32'(busy), 0);

      // Ball wins after reset even though paddle requests too
      lat = 2;
      @(negedge clk);
      n = cyc;
      service(0, 0, 1, 0, 0, 5, 5, 2, 2, n);
      service(1, 0, 1, 0, 0, 30, 30, 3, 3, -1);
      req = 3'b011;
      wait_ack(0, 40);
      req[0] = 1'b0;
      wait_ack(1, 40);
      req[1] = 1'b0;

      repeat (5) @(negedge clk);
      check("sb_empty", 32'(sb.size()), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/plot_scheduler.md
# plot_scheduler

Arbitrates screen-update requests from the ball, paddle and block game-logic sources and sequences them onto the single rectangle plotter in front of the VGA adapter. Each granted request is serviced as an optional erase of the old rectangle in background colour, then an optional draw of the new rectangle in the object colour, then a one-cycle acknowledge. It sits between the game-logic blocks and the plotter/VGA path, replacing per-source `startPlot`/`object` muxing.

## Interface
- `MAX_X`, 159, rightmost visible column
- `MAX_Y`, 119, bottom visible row
- `BG_COLOUR`, 3'b000, colour used for erase phase
- `BALL_COLOUR`, 3'b111, draw colour for requester 0
- `PADDLE_COLOUR`, 3'b010, draw colour for requester 1
- `BLOCK_COLOUR`, 3'b100, draw colour for requester 2
- `clk`  in  1  system clock
- `resetn`  in  1  asynchronous, active-low reset
- `req`  in  3  request per source: bit0 ball, bit1 paddle, bit2 block
- `erase_en`  in  3  per source: perform erase phase
- `draw_en`  in  3  per source: perform draw phase
- `new_x`  in  24  packed 3×8, source i in [8i+7:8i]
- `new_y`  in  21  packed 3×7
- `old_x`  in  24  packed 3×8
- `old_y`  in  21  packed 3×7
- `size_x`  in  24  packed 3×8, rectangle width
- `size_y`  in  21  packed 3×7, rectangle height
- `ack`  out  3  one-cycle pulse, request serviced
- `plot_start`  out  1  one-cycle pulse to plotter
- `plot_x`, `plot_y`  out  8, 7  rectangle origin
- `plot_w`, `plot_h`  out  8, 7  rectangle size (clipped)
- `plot_colour`  out  3  rectangle colour
- `plot_done`  in  1  one-cycle pulse from plotter, rectangle finished
- `busy`  out  1  high in every state except IDLE

## Operation
- States: IDLE, ERASE_START, ERASE_WAIT, DRAW_START, DRAW_WAIT, ACK.
- IDLE: if any `req` bit set, round-robin grant: search starts at (last_grant+1) mod 3. Latch the winner's index, enables, coordinates and sizes into internal registers; later input changes have no effect on the request in flight.
- After grant: go to ERASE_START if erase phase is valid, else DRAW_START if draw phase is valid, else ACK.
- Phase valid = enable bit set, origin on screen (x ≤ MAX_X, y ≤ MAX_Y), width and height both nonzero.
- Clipping: w' = min(w, MAX_X+1−x), h' = min(h, MAX_Y+1−y); sums computed at 9/8 bits, no wrap.
- ERASE_START: `plot_start`=1, old origin, clipped size, `BG_COLOUR`; go to ERASE_WAIT.
- ERASE_WAIT: on `plot_done`, go to DRAW_START if draw valid, else ACK.
- DRAW_START: `plot_start`=1, new origin, clipped size, source colour; go to DRAW_WAIT.
- DRAW_WAIT: on `plot_done`, go to ACK.
- ACK: `ack[winner]`=1 for one cycle; last_grant ← winner; go to IDLE.
- `plot_done` is only honoured in the WAIT states; it is ignored elsewhere, including the START cycle.
- A `req` bit that drops before it is granted is simply not serviced. Sources hold `req` until they see `ack`. A source still requesting in the cycle after its `ack` is re-arbitrated normally.
- Reset values:
  - state IDLE, last_grant = 2 (ball wins first)
  - all outputs 0
  - latched registers 0
- Asserting `resetn` mid-operation aborts the request with no `ack`. Any later `plot_done` from the aborted rectangle is ignored, since the scheduler is in IDLE.

## Timing
- Between START and WAIT, `plot_x`/`plot_y`/`plot_w`/`plot_h`/`plot_colour` are registered and hold stable until the next START.
- `req` sampled in IDLE at cycle N; first `plot_start` at N+1.
- Erase `plot_done` at cycle D gives draw `plot_start` at D+1. Final `plot_done` at E gives `ack` at E+1, IDLE at E+2, next grant evaluated at E+2.
- If neither phase is valid, `ack` occurs at N+1.
- Single-phase request with plotter latency L cycles (done L cycles after start): `ack` at N+L+2.

## Test plan
- Ball only, erase+draw, old (50,4) new (51,5) size 4×4, plotter done 3 cycles after start:
  - starts at N+1 (BG, 50,4,4,4) and N+5 (3'b111, 51,5,4,4)
  - `ack`=3'b001 at N+9
- All three `req` held continuously, both enables set: grant order ball, paddle, block, ball, …; each `ack` bit pulses exactly once per service.
- Clipping:
  - paddle new (150,125), size 16×1 → no draw (y off-screen)
  - paddle new (150,117), size 16×1 → `plot_w`=10, `plot_h`=1
- Block with erase_en=1, draw_en=0: exactly one `plot_start` carrying `BG_COLOUR`, then `ack`=3'b100.
- Both enables 0: no `plot_start`; `ack` one cycle after grant.
- `resetn` low during DRAW_WAIT:
  - all outputs 0 immediately, no `ack`
  - stray `plot_done` afterwards causes no `plot_start`
  - next request is serviced from IDLE with ball priority.
